// File: rtl/ifid_stage_ctrl.sv
// -----------------------------------------------------------------------------
// ifid_stage_ctrl
//
// Fetch-side control for a classic 5-stage pipeline. This block owns:
//   - the program counter
//   - the IF/ID pipeline register
//   - a consecutive-stall watchdog
//
// Each clock edge takes exactly one action, in this priority order:
//   stall  : hold pc and IF/ID. Any flush is ignored, because the branch
//            that raised it is itself waiting on stalled operands.
//   flush  : redirect pc to the word-aligned branch_target and squash IF/ID.
//   advance: pc <= pc+4, and capture imem_instr into IF/ID.
//
// There is no valid/ready handshake here. stall and flush are level
// requests that are sampled on every rising edge of clk.
//
// Ports:
//   clk, rst_n     rising-edge clock; asynchronous active-low reset
//   stall          hold request from the hazard unit
//   flush          taken branch/jump resolved in ID
//   branch_target  redirect address (used when flush=1)
//   imem_instr     instruction memory data for address pc
//   pc             current fetch address (registered, always word aligned)
//   ifid_instr     IF/ID instruction (registered)
//   ifid_pc_plus4  IF/ID PC+4 (registered)
//   ifid_valid     IF/ID holds a real instruction (registered)
//   pc_write       PC update enable (combinational, = !stall)
//   idex_bubble    zero the ID/EX control lines this cycle (combinational)
//   stall_count    consecutive stall cycles, saturating at 255 (registered)
//   stall_timeout  sticky watchdog flag, cleared only by reset (registered)
// -----------------------------------------------------------------------------
module ifid_stage_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [7:0]  MAX_STALL = 8'd15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] branch_target,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        pc_write,
  output logic        idex_bubble,
  output logic [7:0]  stall_count,
  output logic        stall_timeout
);

  // pc[1:0] is tied low both at reset and on every redirect.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  localparam logic [7:0]  TIMEOUT_AT       = MAX_STALL - 8'd1;

  logic [31:0] pc_plus4;

  // The sum deliberately wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
  assign pc_plus4 = pc + 32'd4;

  assign pc_write    = !stall;
  assign idex_bubble = stall || !ifid_valid;

  // PC and IF/ID register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC_ALIGNED;
      ifid_instr    <= 32'h0000_0000;
      ifid_pc_plus4 <= 32'h0000_0000;
      ifid_valid    <= 1'b0;
    end else if (stall) begin
      pc            <= pc;
      ifid_instr    <= ifid_instr;
      ifid_pc_plus4 <= ifid_pc_plus4;
      ifid_valid    <= ifid_valid;
    end else if (flush) begin
      pc            <= {branch_target[31:2], 2'b00};
      ifid_instr    <= 32'h0000_0000;
      ifid_pc_plus4 <= 32'h0000_0000;
      ifid_valid    <= 1'b0;
    end else begin
      pc            <= pc_plus4;
      ifid_instr    <= imem_instr;
      ifid_pc_plus4 <= pc_plus4;
      ifid_valid    <= 1'b1;
    end
  end

  // Stall watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count   <= 8'd0;
      stall_timeout <= 1'b0;
    end else if (stall) begin
      if (stall_count != 8'hFF) begin
        stall_count <= stall_count + 8'd1;
      end
      // Fires on the MAX_STALL-th consecutive stall edge, then sticks.
      if (stall_count == TIMEOUT_AT) begin
        stall_timeout <= 1'b1;
      end
    end else begin
      stall_count <= 8'd0;
    end
  end

endmodule

// File: tb/tb_ifid_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ifid_stage_ctrl
//
// Drives directed and random fetch traffic into ifid_stage_ctrl. Every output
// is compared against a reference model that is kept at the architectural
// level:
//   - the PC is treated as a plain modulo-2^32 address
//   - the watchdog is tracked as an unbounded run length of consecutive
//     stalls, from which the saturated count and the sticky flag are derived
// -----------------------------------------------------------------------------
module tb_ifid_stage_ctrl;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [7:0]  MAX_STALL = 8'd15;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic        stall, flush;
  logic [31:0] branch_target, imem_instr;
  logic [31:0] pc, ifid_instr, ifid_pc_plus4;
  logic        ifid_valid, pc_write, idex_bubble, stall_timeout;
  logic [7:0]  stall_count;

  ifid_stage_ctrl #(
    .RESET_PC  (RESET_PC),
    .MAX_STALL (MAX_STALL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .imem_instr    (imem_instr),
    .pc            (pc),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid),
    .pc_write      (pc_write),
    .idex_bubble   (idex_bubble),
    .stall_count   (stall_count),
    .stall_timeout (stall_timeout)
  );

  // ---------------------------------------------------------------------------
  // Reference model (architectural view)
  // ---------------------------------------------------------------------------
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_run;     // consecutive stall edges, unbounded
  logic        m_to;      // watchdog has ever seen run >= MAX_STALL

  int checks = 0;
  int errors = 0;

  function automatic void model_reset();
    m_pc    = RESET_PC & 32'hFFFF_FFFC;
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
    m_run   = 0;
    m_to    = 1'b0;
  endfunction

  function automatic void model_edge(input logic s, input logic f,
                                     input logic [31:0] tgt,
                                     input logic [31:0] instr);
    logic [31:0] next_addr;
    if (s) begin
      m_run = m_run + 1;
      if (m_run >= int'(MAX_STALL)) m_to = 1'b1;
    end else begin
      m_run = 0;
      if (f) begin
        m_pc    = tgt & 32'hFFFF_FFFC;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
      end else begin
        next_addr = m_pc + 32'd4;
        m_pc      = next_addr;
        m_pc4     = next_addr;
        m_instr   = instr;
        m_valid   = 1'b1;
      end
    end
  endfunction

  function automatic logic [31:0] model_count();
    return (m_run > 255) ? 32'd255 : 32'(m_run);
  endfunction

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".pc"},            pc,                    m_pc);
    chk({tag, ".ifid_instr"},    ifid_instr,            m_instr);
    chk({tag, ".ifid_pc_plus4"}, ifid_pc_plus4,         m_pc4);
    chk({tag, ".ifid_valid"},    32'(ifid_valid),       32'(m_valid));
    chk({tag, ".stall_count"},   32'(stall_count),      model_count());
    chk({tag, ".stall_timeout"}, 32'(stall_timeout),    32'(m_to));
  endtask

  task automatic check_comb(input string tag);
    chk({tag, ".pc_write"},    32'(pc_write),    32'(!stall));
    chk({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(stall || !m_valid));
  endtask

  // ---------------------------------------------------------------------------
  // Driver: apply inputs just after an edge, check the combinational outputs,
  // clock once, then check the registered state against the model.
  // ---------------------------------------------------------------------------
  task automatic step(input string tag, input logic s, input logic f,
                      input logic [31:0] tgt, input logic [31:0] instr);
    stall         = s;
    flush         = f;
    branch_target = tgt;
    imem_instr    = instr;
    #1;
    check_comb({tag, ".pre"});
    @(posedge clk);
    model_edge(s, f, tgt, instr);
    #1;
    check_regs(tag);
  endtask

  // Assert reset between edges and confirm the outputs react with no edge.
  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs(tag);
    check_comb(tag);
    rst_n = 1'b1;
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed + random sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic s, f;

    rst_n         = 1'b0;
    stall         = 1'b0;
    flush         = 1'b0;
    branch_target = 32'h0;
    imem_instr    = 32'h0;
    model_reset();

    // Reset state, before any edge and across one edge held in reset.
    #2;
    check_regs("reset0");
    check_comb("reset0");
    @(posedge clk);
    #1;
    check_regs("reset1");
    stall = 1'b1;
    #1;
    check_comb("reset_stall");
    stall = 1'b0;
    rst_n = 1'b1;
    #1;

    // Free run after release: A, B, C.
    step("run_a", 1'b0, 1'b0, 32'h0, 32'hA0A0_0001);
    step("run_b", 1'b0, 1'b0, 32'h0, 32'hB0B0_0002);
    step("run_c", 1'b0, 1'b0, 32'h0, 32'hC0C0_0003);
    chk("run_c.pc_is_c", pc, 32'h0000_000C);
    step("run_d", 1'b0, 1'b0, 32'h0, 32'hD0D0_0004);

    // Load-use stall at pc=0x10.
    chk("loaduse.pc_at_10", pc, 32'h0000_0010);
    step("loaduse_stall", 1'b1, 1'b0, 32'h0, 32'hEEEE_0005);
    chk("loaduse.count1", 32'(stall_count), 32'd1);
    step("loaduse_resume", 1'b0, 1'b0, 32'h0, 32'hEEEE_0005);
    chk("loaduse.pc_14", pc, 32'h0000_0014);

    // Taken branch to an unaligned target.
    step("branch", 1'b0, 1'b1, 32'h0000_0103, 32'h1111_1111);
    chk("branch.pc_100", pc, 32'h0000_0100);
    stall = 1'b0;
    flush = 1'b0;
    #1;
    chk("branch.bubble", 32'(idex_bubble), 32'd1);

    // Stall and flush together: stall wins; then the flush alone redirects.
    step("stall_flush",  1'b1, 1'b1, 32'h0000_0200, 32'h2222_2222);
    step("flush_after",  1'b0, 1'b1, 32'h0000_0200, 32'h2222_2222);
    chk("flush_after.pc_200", pc, 32'h0000_0200);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 4) == 0);
      step("rand", s, f, $urandom, $urandom);
    end
    step("rand_clear", 1'b0, 1'b0, 32'h0, 32'h3333_3333);

    // Reset mid-stall discards in-flight state, then watchdog from clean.
    step("midstall_a", 1'b1, 1'b1, 32'h0000_0400, 32'h0);
    step("midstall_b", 1'b1, 1'b0, 32'h0, 32'h0);
    async_reset("midstall_rst");
    step("first_fetch", 1'b0, 1'b0, 32'h0, 32'h4444_4444);
    chk("first_fetch.pc4", ifid_pc_plus4, RESET_PC + 32'd4);

    // Watchdog: 15 stalls trip the flag on the 15th edge.
    for (int i = 0; i < 14; i++) step("wd_pre", 1'b1, 1'b0, 32'h0, 32'h0);
    chk("wd.not_yet", 32'(stall_timeout), 32'd0);
    step("wd_15th", 1'b1, 1'b0, 32'h0, 32'h0);
    chk("wd.tripped", 32'(stall_timeout), 32'd1);
    step("wd_release", 1'b0, 1'b0, 32'h0, 32'h5555_5555);
    chk("wd.sticky", 32'(stall_timeout), 32'd1);
    for (int i = 0; i < 300; i++) step("wd_sat", 1'b1, 1'b0, 32'h0, 32'h0);
    chk("wd.saturated", 32'(stall_count), 32'd255);

    // PC wrap: redirect to the top word, then advance.
    step("wrap_redirect", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0);
    chk("wrap.pc_top", pc, 32'hFFFF_FFFC);
    step("wrap_advance", 1'b0, 1'b0, 32'h0, 32'h6666_6666);
    chk("wrap.pc_zero", pc, 32'h0000_0000);
    chk("wrap.pc4_zero", ifid_pc_plus4, 32'h0000_0000);

    // Async reset pulse between edges.
    async_reset("async_rst");
    step("post_rst", 1'b0, 1'b0, 32'h0, 32'h7777_7777);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifid_stage_ctrl.md
IFID_STAGE_CTRL -- requirements
Module: ifid_stage_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter MAX_STALL, default 8'd15, meaning the consecutive-stall cycle count that raises the stall timeout.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock for all state.
REQ-004 The block SHALL have the reset port: rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have the port: stall  input  1  load-use/branch-operand stall request from the hazard detection unit.
REQ-006 The block SHALL have the port: flush  input  1  branch/jump taken, resolved in ID.
REQ-007 The block SHALL have the port: branch_target  input  32  redirect address, valid when flush=1.
REQ-008 The block SHALL have the port: imem_instr  input  32  instruction memory read data for address pc.
REQ-009 The block SHALL have the port: pc  output  32  current fetch address, registered.
REQ-010 The block SHALL have the port: ifid_instr  output  32  IF/ID instruction, registered.
REQ-011 The block SHALL have the port: ifid_pc_plus4  output  32  IF/ID PC+4, registered.
REQ-012 The block SHALL have the port: ifid_valid  output  1  IF/ID holds a real instruction, registered.
REQ-013 The block SHALL have the port: pc_write  output  1  PC update enable, combinational.
REQ-014 The block SHALL have the port: idex_bubble  output  1  zero ID/EX control lines this cycle, combinational.
REQ-015 The block SHALL have the port: stall_count  output  8  consecutive stall cycles, registered.
REQ-016 The block SHALL have the port: stall_timeout  output  1  sticky stall-watchdog flag, registered.

Function
REQ-017 The block SHALL drive pc_write = !stall.
REQ-018 The block SHALL drive idex_bubble = stall || !ifid_valid.
REQ-019 The block SHALL apply priority at each clock edge in the order stall, then flush, then normal advance.
REQ-020 On stall=1, the block SHALL hold pc, ifid_instr, ifid_pc_plus4 and ifid_valid and SHALL ignore flush, because the branch decision is invalid while its operands are stalled.
REQ-021 On stall=0 and flush=1, the block SHALL load pc <= {branch_target[31:2],2'b00}.
REQ-022 On stall=0 and flush=1, the block SHALL load ifid_instr <= 32'h0000_0000, ifid_pc_plus4 <= 0 and ifid_valid <= 0.
REQ-023 On stall=0 and flush=0, the block SHALL load pc <= pc+4, ifid_instr <= imem_instr, ifid_pc_plus4 <= pc+4 and ifid_valid <= 1.
REQ-024 PC arithmetic SHALL be 32-bit modulo, so pc=32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
REQ-025 pc[1:0] SHALL always be 2'b00.
REQ-026 The block SHALL increment stall_count on every edge with stall=1, saturating at 8'hFF.
REQ-027 The block SHALL clear stall_count to 0 on every edge with stall=0.
REQ-028 The block SHALL set stall_timeout on the edge where stall=1 and stall_count == MAX_STALL-1, i.e. at the MAX_STALL-th consecutive stall cycle.
REQ-029 stall_timeout SHALL remain set until reset, including after stall deasserts.
REQ-030 Latency SHALL be one cycle: an instruction presented on imem_instr appears on ifid_instr on the next edge, and a flush redirect appears on pc on the next edge.

Reset
REQ-031 While rst_n=0, regardless of clk, the block SHALL force pc=RESET_PC, ifid_instr=0, ifid_pc_plus4=0, ifid_valid=0, stall_count=0 and stall_timeout=0.
REQ-032 Reset asserted mid-stall or mid-flush SHALL discard all in-flight state.
REQ-033 The first edge after rst_n rises with stall=0 and flush=0 SHALL capture the instruction fetched at RESET_PC.
REQ-034 During reset, idex_bubble SHALL be 1 (ifid_valid=0) and pc_write SHALL follow !stall.

Verification
REQ-035 The bench SHALL cover reset then free run: rst_n release, 3 edges with imem_instr=A,B,C -> pc=0x4,0x8,0xC; ifid_instr=A,B,C; ifid_pc_plus4=0x4,0x8,0xC; ifid_valid=1 from the 1st edge.
REQ-036 The bench SHALL cover a load-use stall: stall=1 for 1 cycle at pc=0x10 -> pc_write=0 and idex_bubble=1 that cycle; pc and IF/ID held; next edge pc=0x14; stall_count 1 then 0.
REQ-037 The bench SHALL cover a taken branch: flush=1 with branch_target=0x0000_0103 -> pc=0x100, ifid_instr=0, ifid_valid=0, idex_bubble=1 the following cycle.
REQ-038 The bench SHALL cover simultaneous stall and flush: stall=1 and flush=1 with branch_target=0x200 -> no redirect, state held; next cycle stall=0, flush=1 -> pc=0x200.
REQ-039 The bench SHALL cover the watchdog: stall=1 for 15 cycles with MAX_STALL=15 -> stall_timeout=1 after the 15th edge; stall=0 -> stall_count=0 and stall_timeout stays 1; stall=1 for 300 cycles -> stall_count saturates at 255.
REQ-040 The bench SHALL cover wrap and async reset: pc=0xFFFF_FFFC, advance -> pc=0; rst_n pulsed low between edges -> outputs at reset values immediately, with no clock edge needed.
